// File: rtl/mdu_pkg.sv
// Shared widths, opcode and state encodings for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned DLEN = 2 * XLEN;
    localparam int unsigned CNTW = 5;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [XLEN-1:0] LO_DIV0 = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negation, used for operand magnitude and result sign correction.
module mdu_signfix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_c_o
);

    assign res_c_o = neg_i ? W'(~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit with private HI/LO registers.
// Define MDU_FAST_MUL_EN to route MULT/MULTU through a single-cycle multiplier.
module mdu
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            we_hi,
    input  logic            we_lo,
    input  logic [XLEN-1:0] d,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [DLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d, a_q, a_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic              sgn_in;
    logic [XLEN-1:0]   abs_a, abs_b, quot_fix, rem_fix;
    logic [DLEN-1:0]   prod_raw, prod_fix;
    logic [XLEN:0]     mul_sum, div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;

    assign sgn_in = ~op[0];

    mdu_signfix #(.W(XLEN)) u_abs_a (.val_i(a), .neg_i(sgn_in & a[XLEN-1]), .res_c_o(abs_a));
    mdu_signfix #(.W(XLEN)) u_abs_b (.val_i(b), .neg_i(sgn_in & b[XLEN-1]), .res_c_o(abs_b));
    mdu_signfix #(.W(DLEN)) u_fix_p (.val_i(prod_raw), .neg_i(qneg_q), .res_c_o(prod_fix));
    mdu_signfix #(.W(XLEN)) u_fix_q (.val_i(acc_q[XLEN-1:0]), .neg_i(qneg_q), .res_c_o(quot_fix));
    mdu_signfix #(.W(XLEN)) u_fix_r (.val_i(acc_q[DLEN-1:XLEN]), .neg_i(rneg_q), .res_c_o(rem_fix));

    // Shift-add step: upper half accumulates, multiplier bits shift out of the lower half.
    assign mul_sum = {1'b0, acc_q[DLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mag_a_q : '0)};

    // Restoring step: remainder lives in the upper half, dividend/quotient in the lower half.
    assign div_sh  = {acc_q[DLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge  = div_sh >= {1'b0, mag_b_q};
    assign div_rem = div_ge ? XLEN'(div_sh - {1'b0, mag_b_q}) : div_sh[XLEN-1:0];

`ifdef MDU_FAST_MUL_EN
    assign prod_raw = {{XLEN{1'b0}}, mag_a_q} * {{XLEN{1'b0}}, mag_b_q};
`else
    assign prod_raw = acc_q;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            a_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            a_q     <= a_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        a_d     = a_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    mag_a_d = abs_a;
                    mag_b_d = abs_b;
                    qneg_d  = sgn_in & (a[XLEN-1] ^ b[XLEN-1]);
                    rneg_d  = sgn_in & a[XLEN-1];
                    cnt_d   = '0;
                    acc_d   = {{XLEN{1'b0}}, (op[1] ? abs_a : abs_b)};
                    state_d = S_RUN;
`ifdef MDU_FAST_MUL_EN
                    if (!op[1]) state_d = S_FIX;
`endif
                end else begin
                    if (we_hi) hi_d = d;
                    if (we_lo) lo_d = d;
                end
            end
            S_RUN: begin
                acc_d = op_q[1] ? {div_rem, acc_q[XLEN-2:0], div_ge}
                                : {mul_sum, acc_q[XLEN-1:1]};
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(31)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!op_q[1]) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (mag_b_q == '0) begin
                    hi_d = a_q;
                    lo_d = LO_DIV0;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
